fifo_uart_tx: RTL

Downstream consumer of the synchronous FIFO. Pops DATA_WIDTH-bit words through the FIFO read port (cs/rd_en/empty/data_out) and serialises each word as DATA_WIDTH/8 UART 8N1 frames, least significant byte first. It accounts for the FIFO's registered read data, which is valid one cycle after the pop. It drives the board-level TX pin and reports progress to the control logic.

---
 rtl/fifo_uart_pkg.sv | 25 ++
 rtl/uart_baud_cnt.sv | 34 +++
 rtl/fifo_uart_tx.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/fifo_uart_pkg.sv
// Shared types and sizing helpers for the FIFO-fed UART transmitter.
package fifo_uart_pkg;

  localparam int unsigned BITS_PER_BYTE = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_POP   = 3'd1,
    ST_LOAD  = 3'd2,
    ST_START = 3'd3,
    ST_DATA  = 3'd4,
    ST_STOP  = 3'd5
  } state_e;

  // Number of UART bytes carried by one FIFO word.
  function automatic int unsigned calc_bytes(input int unsigned data_width);
    return data_width / BITS_PER_BYTE;
  endfunction

  // Bits needed to index n items (at least one bit).
  function automatic int unsigned calc_idx_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Loadable down-counter; done_c flags the last cycle of a UART bit.
module uart_baud_cnt
  import fifo_uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  output logic done_c
);

  localparam int unsigned CW = calc_idx_w(CLKS_PER_BIT);

  if (CLKS_PER_BIT < 2) begin : g_bad_cpb
    $error("uart_baud_cnt: CLKS_PER_BIT must be >= 2");
  end

  logic [CW-1:0] cnt;

  // Reload at bit entry, then count down and hold at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= CW'(CLKS_PER_BIT - 1);
    end else if (cnt != '0) begin
      cnt <= cnt - CW'(1);
    end
  end

  assign done_c = (cnt == '0);

endmodule

// File: rtl/fifo_uart_tx.sv
// Pops FIFO words and sends each as DATA_WIDTH/8 UART 8N1 frames, LSB byte first.
module fifo_uart_tx
  import fifo_uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned CNT_WIDTH    = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_cs,
  output logic                  fifo_rd_en,
  output logic                  tx,
  output logic                  busy,
  output logic [CNT_WIDTH-1:0]  words_sent
);

  localparam int unsigned BYTES  = calc_bytes(DATA_WIDTH);
  localparam int unsigned BYTE_W = calc_idx_w(BYTES);
  localparam int unsigned BIT_W  = 3;

  if ((DATA_WIDTH % 8) != 0 || DATA_WIDTH == 0) begin : g_bad_dw
    $error("fifo_uart_tx: DATA_WIDTH must be a non-zero multiple of 8");
  end

  if (CLKS_PER_BIT < 2) begin : g_bad_cpb
    $error("fifo_uart_tx: CLKS_PER_BIT must be >= 2");
  end

  state_e                state;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic [BYTE_W-1:0]     byte_idx;
  logic [BIT_W-1:0]      bit_idx;
  logic [7:0]            cur_byte_c;
  logic                  bit_done_c;
  logic                  load_c;
  logic                  more_words_c;
  logic                  last_byte_c;

  uart_baud_cnt #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (load_c),
    .done_c (bit_done_c)
  );

  // Byte of the captured word currently being serialised.
  always_comb begin
    cur_byte_c = '0;
    for (int unsigned b = 0; b < BYTES; b++) begin
      if (byte_idx == BYTE_W'(b)) begin
        cur_byte_c = shift_reg[8*b +: 8];
      end
    end
  end

  // Baud reload on every bit entry: first start bit out of LOAD, then each bit boundary.
  always_comb begin
    load_c = 1'b0;
    if (state == ST_LOAD) begin
      load_c = 1'b1;
    end else if ((state == ST_START || state == ST_DATA || state == ST_STOP) && bit_done_c) begin
      load_c = 1'b1;
    end
  end

  assign more_words_c = enable && !fifo_empty;
  assign last_byte_c  = (byte_idx == BYTE_W'(BYTES - 1));

  // Main sequencer; every output is set on the transition into the state that owns it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      tx         <= 1'b1;
      fifo_cs    <= 1'b0;
      fifo_rd_en <= 1'b0;
      busy       <= 1'b0;
      words_sent <= '0;
      byte_idx   <= '0;
      bit_idx    <= '0;
      shift_reg  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (more_words_c) begin
            state      <= ST_POP;
            fifo_cs    <= 1'b1;
            fifo_rd_en <= 1'b1;
            busy       <= 1'b1;
          end
        end
        ST_POP: begin
          state      <= ST_LOAD;
          fifo_cs    <= 1'b0;
          fifo_rd_en <= 1'b0;
        end
        ST_LOAD: begin
          shift_reg <= fifo_data;
          byte_idx  <= '0;
          bit_idx   <= '0;
          tx        <= 1'b0;
          state     <= ST_START;
        end
        ST_START: begin
          if (bit_done_c) begin
            state   <= ST_DATA;
            bit_idx <= '0;
            tx      <= cur_byte_c[0];
          end
        end
        ST_DATA: begin
          if (bit_done_c) begin
            if (bit_idx == BIT_W'(7)) begin
              state <= ST_STOP;
              tx    <= 1'b1;
            end else begin
              bit_idx <= bit_idx + BIT_W'(1);
              tx      <= cur_byte_c[bit_idx + BIT_W'(1)];
            end
          end
        end
        ST_STOP: begin
          if (bit_done_c) begin
            if (!last_byte_c) begin
              byte_idx <= byte_idx + BYTE_W'(1);
              state    <= ST_START;
              tx       <= 1'b0;
            end else begin
              words_sent <= words_sent + CNT_WIDTH'(1);
              if (more_words_c) begin
                state      <= ST_POP;
                fifo_cs    <= 1'b1;
                fifo_rd_en <= 1'b1;
              end else begin
                state <= ST_IDLE;
                busy  <= 1'b0;
              end
            end
          end
        end
        default: begin
          state      <= ST_IDLE;
          tx         <= 1'b1;
          fifo_cs    <= 1'b0;
          fifo_rd_en <= 1'b0;
          busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule
